// File: rtl/can_timing_pkg.sv
// Shared types, default widths and the majority voter for the CAN bit-timing stage.
package can_timing_pkg;

    typedef enum logic [1:0] {
        s_sync  = 2'd0,
        s_tseg1 = 2'd1,
        s_tseg2 = 2'd2
    } seg_t;

    localparam int BRP_W_DEF   = 6;
    localparam int TSEG1_W_DEF = 4;
    localparam int TSEG2_W_DEF = 3;
    localparam int SJW_W_DEF   = 2;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/can_tq_prescaler.sv
// Divides clk into time quanta: tqTick is high on the last clk of every (brp+1)-clk quantum.
module can_tq_prescaler #(
    parameter int BRP_W = 6
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             clear,
    input  logic [BRP_W-1:0] brp,
    output logic             tqTick
);

    logic [BRP_W-1:0] preCnt;

    assign tqTick = (preCnt == brp);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            preCnt <= '0;
        end else if (clear || tqTick) begin
            preCnt <= '0;
        end else begin
            preCnt <= preCnt + 1'b1;
        end
    end

endmodule

// File: rtl/can_bit_sampler.sv
// CAN bit timing: synchronises rxIn, tracks SYNC/TSEG1/TSEG2 with hard sync and
// SJW-limited resync, and produces samplePulse/dOut/bitStart for the interframe detector.
module can_bit_sampler
    import can_timing_pkg::*;
#(
    parameter int BRP_W   = BRP_W_DEF,
    parameter int TSEG1_W = TSEG1_W_DEF,
    parameter int TSEG2_W = TSEG2_W_DEF,
    parameter int SJW_W   = SJW_W_DEF
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               rxIn,
    input  logic               rateSelector,
    input  logic               hardSyncEn,
    input  logic [BRP_W-1:0]   brp,
    input  logic [TSEG1_W-1:0] tseg1,
    input  logic [TSEG2_W-1:0] tseg2,
    input  logic [SJW_W-1:0]   sjw,
    output logic               samplePulse,
    output logic               dOut,
    output logic               bitStart
);

    localparam int CNT_W = ((TSEG1_W > TSEG2_W) ? TSEG1_W : TSEG2_W) + 1;
    localparam int CW1   = CNT_W + 1;
    localparam int EXT_W = SJW_W + 1;

    logic rxMeta, rxSync, rxPrev, fallEdge;
    logic tqTick, hardSync, resyncEv, remSmall, jumpNow, enterBit, finalPulse;
    seg_t state, nextState;
    logic [CNT_W-1:0] tqCnt, nextCnt, t1End, t2End;
    logic [EXT_W-1:0] ext;
    logic t2Cut, earlyJump, resyncDone;
    logic [1:0] smp;

    logic [BRP_W-1:0]   brpLat, brpEff;
    logic [TSEG1_W-1:0] tseg1Lat, tseg1Eff;
    logic [TSEG2_W-1:0] tseg2Lat, tseg2Eff;
    logic [SJW_W-1:0]   sjwLat, sjwEff;
    logic               rateLat, rateEff;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
            rxPrev <= 1'b1;
        end else begin
            rxMeta <= rxIn;
            rxSync <= rxMeta;
            rxPrev <= rxSync;
        end
    end

    assign fallEdge = rxPrev & ~rxSync;
    assign hardSync = fallEdge & hardSyncEn;
    assign resyncEv = fallEdge & ~hardSyncEn & ~resyncDone;

    // Config is transparent during SYNC and frozen for the rest of the bit.
    assign brpEff   = (state == s_sync) ? brp          : brpLat;
    assign tseg1Eff = (state == s_sync) ? tseg1        : tseg1Lat;
    assign tseg2Eff = (state == s_sync) ? tseg2        : tseg2Lat;
    assign sjwEff   = (state == s_sync) ? sjw          : sjwLat;
    assign rateEff  = (state == s_sync) ? rateSelector : rateLat;

    // NOTE: the config holding registers get a reset value even though SYNC reloads them,
    // so no X can reach the comparators in the first cycle after reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            brpLat   <= '0;
            tseg1Lat <= '0;
            tseg2Lat <= '0;
            sjwLat   <= '0;
            rateLat  <= 1'b0;
        end else if (state == s_sync) begin
            brpLat   <= brp;
            tseg1Lat <= tseg1;
            tseg2Lat <= tseg2;
            sjwLat   <= sjw;
            rateLat  <= rateSelector;
        end
    end

    can_tq_prescaler #(.BRP_W(BRP_W)) uPrescaler (
        .clk    (clk),
        .resetN (resetN),
        .clear  (hardSync),
        .brp    (brpEff),
        .tqTick (tqTick)
    );

    assign t1End    = CNT_W'(tseg1Eff) + CNT_W'(ext);
    assign t2End    = t2Cut ? CNT_W'(tseg2Eff) - CNT_W'(sjwEff) - CNT_W'(1) : CNT_W'(tseg2Eff);
    // rem = tseg2 - tqCnt < sjw+1, rearranged so nothing goes negative.
    assign remSmall = CW1'(tseg2Eff) <= CW1'(tqCnt) + CW1'(sjwEff);
    assign jumpNow  = earlyJump | (resyncEv & (state == s_tseg2) & remSmall);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= s_sync;
            tqCnt    <= '0;
            bitStart <= 1'b0;
        end else begin
            state    <= nextState;
            tqCnt    <= nextCnt;
            bitStart <= enterBit;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        nextState = state;
        nextCnt   = tqCnt;
        enterBit  = 1'b0;
        if (hardSync) begin
            nextState = s_tseg1;
            nextCnt   = '0;
            enterBit  = 1'b1;
        end else if (tqTick) begin
            case (state)
                s_sync: begin
                    nextState = s_tseg1;
                    nextCnt   = '0;
                end
                s_tseg1: begin
                    if (tqCnt == t1End) begin
                        nextState = s_tseg2;
                        nextCnt   = '0;
                    end else begin
                        nextCnt = tqCnt + 1'b1;
                    end
                end
                s_tseg2: begin
                    if (jumpNow) begin
                        nextState = s_tseg1;
                        nextCnt   = '0;
                        enterBit  = 1'b1;
                    end else if (tqCnt >= t2End) begin
                        nextState = s_sync;
                        nextCnt   = '0;
                        enterBit  = 1'b1;
                    end else begin
                        nextCnt = tqCnt + 1'b1;
                    end
                end
                default: begin
                    nextState = s_sync;
                    nextCnt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        samplePulse = 1'b0;
        finalPulse  = 1'b0;
        if (tqTick && !hardSync && state == s_tseg1) begin
            if (rateEff) begin
                samplePulse = (CW1'(tqCnt) + CW1'(2) >= CW1'(t1End)) && (tqCnt <= t1End);
            end else begin
                samplePulse = (tqCnt == t1End);
            end
            finalPulse = samplePulse && (tqCnt == t1End);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ext        <= '0;
            t2Cut      <= 1'b0;
            earlyJump  <= 1'b0;
            resyncDone <= 1'b0;
        end else if (hardSync || enterBit) begin
            ext        <= '0;
            t2Cut      <= 1'b0;
            earlyJump  <= 1'b0;
            resyncDone <= 1'b0;
        end else if (resyncEv) begin
            resyncDone <= 1'b1;
            if (state == s_tseg1) begin
                ext <= (tqCnt < CNT_W'(sjwEff)) ? EXT_W'(tqCnt) + EXT_W'(1)
                                                : EXT_W'(sjwEff) + EXT_W'(1);
            end else if (state == s_tseg2) begin
                if (remSmall) earlyJump <= 1'b1;
                else          t2Cut     <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            smp  <= 2'b11;
            dOut <= 1'b1;
        end else if (samplePulse) begin
            smp <= {smp[0], rxSync};
            if (finalPulse) begin
                dOut <= rateEff ? majority3(smp[1], smp[0], rxSync) : rxSync;
            end
        end
    end

endmodule

// File: tb/tb_can_bit_sampler.sv
// Directed bench for can_bit_sampler: nominal timing, triple sampling, hard sync,
// late/early resync and asynchronous reset, all with brp=1 tseg1=5 tseg2=2 sjw=1.
module tb_can_bit_sampler;

    logic       clk = 1'b0;
    logic       resetN, rxIn, rateSelector, hardSyncEn;
    logic [5:0] brp;
    logic [3:0] tseg1;
    logic [2:0] tseg2;
    logic [1:0] sjw;
    logic       samplePulse, dOut, bitStart;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pulseCyc[$];
    int base, edgeCyc, bs1, bs2, bs3, bs4, bs5, bs6, bs7, bs8, bs9, hs, bsr;

    can_bit_sampler dut (
        .clk          (clk),
        .resetN       (resetN),
        .rxIn         (rxIn),
        .rateSelector (rateSelector),
        .hardSyncEn   (hardSyncEn),
        .brp          (brp),
        .tseg1        (tseg1),
        .tseg2        (tseg2),
        .sjw          (sjw),
        .samplePulse  (samplePulse),
        .dOut         (dOut),
        .bitStart     (bitStart)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clk: sample outputs on the falling edge and log strobe positions.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (samplePulse === 1'b1) pulseCyc.push_back(cyc);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_bs(input int limit, output int at);
        at = -1000;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (bitStart === 1'b1) begin
                at = cyc;
                return;
            end
        end
    endtask

    function automatic int pulse_off(input int idx, input int ref_cyc);
        return (pulseCyc.size() > idx) ? pulseCyc[idx] - ref_cyc : -1000;
    endfunction

    initial begin
        resetN = 1'b0; rxIn = 1'b1; rateSelector = 1'b0; hardSyncEn = 1'b0;
        brp = 6'd1; tseg1 = 4'd5; tseg2 = 3'd2; sjw = 2'd1;
        repeat (2) @(negedge clk);
        check("rst_pulse", samplePulse, 0);
        check("rst_bitstart", bitStart, 0);
        check("rst_dout", dOut, 1);

        // Nominal bit: 10 tq = 20 clk, single sample on the 14th clk of the bit.
        resetN = 1'b1; base = cyc; pulseCyc.delete();
        wait_bs(30, bs1);
        check("first_bitstart", bs1 - base, 20);
        check("first_pulse", pulse_off(0, base), 13);
        pulseCyc.delete();
        wait_bs(25, bs2);
        check("nom_len", bs2 - bs1, 20);
        check("nom_count", pulseCyc.size(), 1);
        check("nom_pos", pulse_off(0, bs1), 13);
        check("nom_dout", dOut, 1);

        // Triple sampling; dominant edge placed on the next SYNC so it causes no adjustment.
        rateSelector = 1'b1; pulseCyc.delete();
        ticks(18); rxIn = 1'b0;
        wait_bs(5, bs3);
        check("tri_len", bs3 - bs2, 20);
        check("tri_count", pulseCyc.size(), 3);
        check("tri_p0", pulse_off(0, bs2), 9);
        check("tri_p1", pulse_off(1, bs2), 11);
        check("tri_p2", pulse_off(2, bs2), 13);

        // Dominant bit with a recessive glitch on the middle sample only.
        ticks(9); rxIn = 1'b1; ticks(1); rxIn = 1'b0; ticks(3);
        check("maj1_hold", dOut, 1);
        ticks(1);
        check("maj1_dout", dOut, 0);

        // Recessive over the last two samples outvotes the first.
        wait_bs(10, bs4);
        check("maj2_len", bs4 - bs3, 20);
        ticks(9); rxIn = 1'b1; ticks(4);
        check("maj2_hold", dOut, 0);
        ticks(1);
        check("maj2_dout", dOut, 1);
        rateSelector = 1'b0; hardSyncEn = 1'b1;

        // Hard sync from an edge in the middle of TSEG2.
        wait_bs(10, bs5);
        check("pre_hs_len", bs5 - bs4, 20);
        ticks(14); rxIn = 1'b0; edgeCyc = cyc;
        wait_bs(4, hs);
        check("hs_latency", hs - edgeCyc, 3);
        rxIn = 1'b1; hardSyncEn = 1'b0; pulseCyc.delete();
        wait_bs(25, bs6);
        check("hs_pulse", pulse_off(0, hs), 11);
        check("hs_len", bs6 - hs, 18);
        check("hs_dout", dOut, 1);

        // Late edge at TSEG1 tqCnt=2: ext clamps to 2; a second edge in TSEG2 is ignored.
        pulseCyc.delete();
        ticks(4); rxIn = 1'b0; ticks(4); rxIn = 1'b1; ticks(10); rxIn = 1'b0;
        wait_bs(30, bs7);
        check("late_len", bs7 - bs6, 24);
        check("late_count", pulseCyc.size(), 1);
        check("late_pos", pulse_off(0, bs6), 17);

        // Early edge at TSEG2 tqCnt=2: next bit starts in TSEG1 and is one tq short.
        rxIn = 1'b1; pulseCyc.delete();
        ticks(16); rxIn = 1'b0;
        wait_bs(10, bs8);
        check("early_len", bs8 - bs7, 20);
        pulseCyc.delete();
        ticks(12); rxIn = 1'b1; rateSelector = 1'b1;
        wait_bs(10, bs9);
        check("short_pulse", pulse_off(0, bs8), 11);
        check("short_len", bs9 - bs8, 18);
        check("short_dout", dOut, 0);

        // Reset asserted between the second and third triple samples.
        ticks(11);
        check("mid_tri_pulse", samplePulse, 1);
        #2 resetN = 1'b0;
        #1;
        check("async_pulse", samplePulse, 0);
        check("async_dout", dOut, 1);
        check("async_bitstart", bitStart, 0);
        tick(); resetN = 1'b1; base = cyc; pulseCyc.delete();
        wait_bs(30, bsr);
        check("post_rst_bs", bsr - base, 20);
        check("post_rst_count", pulseCyc.size(), 3);
        check("post_rst_p2", pulse_off(2, base), 13);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/can_bit_sampler.md
Name: can_bit_sampler

Overview:
- Bit-timing and sampling stage directly upstream of the interframe detector.
- Synchronises the raw CAN receive line and divides clk into time quanta (tq).
- Tracks SYNC/TSEG1/TSEG2 with hard sync and SJW-limited resync.
- Drives samplePulse (1 or 3 pulses per bit, per rateSelector) and dOut (the sampled or majority-voted bit), which are the detector's samplePulse and dIn.

Parameters:
- BRP_W, 6: prescaler config width.
- TSEG1_W, 4: tseg1 config width.
- TSEG2_W, 3: tseg2 config width.
- SJW_W, 2: sjw config width.

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous active-low reset.
- rxIn  in  1  raw CAN RX; 1 = recessive, asynchronous to clk.
- rateSelector  in  1  1 = triple sampling, 0 = single sample.
- hardSyncEn  in  1  1 = hard sync allowed (bus idle/interframe; tie to the detector's interframePeriod).
- brp  in  BRP_W  tq = (brp+1) clk.
- tseg1  in  TSEG1_W  TSEG1 length = tseg1+1 tq; must be >=2 when rateSelector=1.
- tseg2  in  TSEG2_W  TSEG2 length = tseg2+1 tq; must be >= sjw.
- sjw  in  SJW_W  resync jump width = sjw+1 tq.
- samplePulse  out  1  one-clk strobe at each sample instant.
- dOut  out  1  sampled bit, held between bits.
- bitStart  out  1  one-clk strobe at each bit start.

Behaviour:
- Reset, asynchronous, active-low:
  - Synchroniser flops = 1; prescaler and tq counters = 0; state = s_sync; resync flag = 0.
  - samplePulse = 0, bitStart = 0, dOut = 1.
- Input path:
  - 2-flop synchroniser, then rxPrev register.
  - fallEdge = rxPrev & ~rxSync (recessive-to-dominant edge).
- Prescaler:
  - preCnt counts 0..brp; tqTick = (preCnt == brp).
  - brp = 0 gives tqTick every clk.
- Config latching:
  - brp, tseg1, tseg2 and sjw are latched on entry to s_sync.
  - Changes mid-bit have no effect.
- FSM, segment counter tqCnt advancing on tqTick:
  - s_sync: 1 tq, then s_tseg1 with tqCnt = 0; bitStart = 1 on the clk entering s_sync.
  - s_tseg1: runs to tqCnt == t1End, then s_tseg2. t1End = tseg1 + ext, where ext is 0 unless set by resync.
  - s_tseg2: runs to tqCnt == t2End, then s_sync. t2End = tseg2 unless shortened by resync.
  - Nominal bit length = tseg1 + tseg2 + 3 tq.
- Sample instants (on tqTick while in s_tseg1):
  - rateSelector = 0: one pulse at tqCnt == t1End.
  - rateSelector = 1: pulses at tqCnt == t1End-2, t1End-1 and t1End.
  - samplePulse is combinational with tqTick and is high for exactly one clk.
  - rateSelector is sampled per bit at s_sync.
- dOut update:
  - Each pulse captures rxSync into a sample shift register.
  - On the clk edge of the final pulse, dOut is loaded with rxSync (single) or majority(s0, s1, rxSync) (triple).
  - dOut is stable from the cycle after the final pulse until the next bit's final pulse.
  - This matches the downstream reader, which consumes dIn one cycle after the third pulse.
- Hard sync, when fallEdge & hardSyncEn:
  - preCnt = 0, state = s_tseg1, tqCnt = 0, ext = 0, resync flag = 0, bitStart = 1.
  - Any pending sample pulses for the aborted bit are cancelled.
- Resync, when fallEdge & ~hardSyncEn & ~resyncDone (at most one per bit; resyncDone is cleared in s_sync):
  - In s_sync: no adjustment, sets resyncDone.
  - In s_tseg1 (late edge): ext = min(tqCnt+1, sjw+1). Sample instants move with t1End.
  - In s_tseg2 (early edge), rem = tseg2 - tqCnt:
    - If rem < sjw+1: at the next tqTick go straight to s_tseg1 with tqCnt = 0, and pulse bitStart; the edge tq is treated as SYNC.
    - Else: t2End = tseg2 - (sjw+1).
- Simultaneous events:
  - Hard sync overrides a same-cycle tqTick and any resync.
  - fallEdge on the same clk as a sample pulse: the sample uses the current rxSync.
- Widths: tqCnt is max(TSEG1_W, TSEG2_W)+1 bits; ext is SJW_W+1 bits; all compares are unsigned with no wrap.

Decomposition:
- Package can_timing_pkg holds:
  - seg_t enum {s_sync, s_tseg1, s_tseg2} with sequential encoding;
  - default width localparams;
  - the majority3 function.
- One sub-module, can_tq_prescaler: counter, tqTick, synchronous clear input for hard sync.

Test Plan:
- Common config for all scenarios: brp=1, tseg1=5, tseg2=2, sjw=1, rateSelector=0, rxIn=1.
  - This gives 10 tq = 20 clk per bit.
  - bitStart every 20 clk; one samplePulse per bit at clk 14 after bitStart (end of tq 7); dOut stays 1.
- rateSelector=1 and a bit driven dominant with a single recessive glitch covering the middle sample:
  - 3 pulses at 2-clk spacing; dOut = 0 (majority).
  - A glitch covering 2 of the 3 samples gives dOut = 1.
- hardSyncEn=1, falling edge mid-tseg2:
  - Within 3 clk (synchroniser latency) the FSM is in s_tseg1 with tqCnt=0 and bitStart pulses.
  - The next samplePulse follows 12 clk later.
- hardSyncEn=0, edge 2 tq late in tseg1:
  - ext limited to 2 (sjw+1); the bit lasts 12 tq = 24 clk.
  - A second edge in the same bit causes no adjustment.
- hardSyncEn=0, edge at tseg2 tqCnt=2 (rem=0):
  - Immediate transition to s_tseg1; the bit is 1 tq short (9 tq).
- resetN asserted mid-triple-sample:
  - samplePulse=0 and dOut=1 immediately (asynchronous).
  - After release, the first bitStart occurs at the first s_sync.
